// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Holds the controller state encoding, the address field widths and the
// helpers that split a CPU word address into {tag, index, offset}.
// The field helpers operate on the package widths; the controller and
// tag store parameters default to these same values.
package cache_pkg;

    localparam int CACHE_OFF_W  = 2;    // 4 words per line
    localparam int CACHE_IDX_W  = 10;   // 1024 lines
    localparam int CACHE_TAG_W  = 4;
    localparam int CACHE_ADDR_W = CACHE_TAG_W + CACHE_IDX_W + CACHE_OFF_W;
    localparam int CACHE_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        FILL_REQ  = 3'd2,
        FILL      = 3'd3,
        WRITE_MEM = 3'd4,
        RESPOND   = 3'd5
    } cache_state_t;

    function automatic logic [CACHE_OFF_W-1:0] addr_offset(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_OFF_W-1:0];
    endfunction

    function automatic logic [CACHE_IDX_W-1:0] addr_index(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_OFF_W +: CACHE_IDX_W];
    endfunction

    function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [CACHE_ADDR_W-1:0] a);
        return a[CACHE_ADDR_W-1 -: CACHE_TAG_W];
    endfunction

endpackage

// File: rtl/cache_controller_tag_store.sv
// Tag/valid store for the direct-mapped cache.
// One (TAG_W+1)-bit entry per line: a tag register and a valid bit.
// Ports:
//   clk, gen_reset (async, active-low: clears every valid bit)
//   rd_idx/rd_tag -> rd_hit : combinational lookup against the stored entry
//   wr_en/wr_idx/wr_tag     : installs a tag and marks the line valid
module tag_store
    import cache_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int TAG_W = CACHE_TAG_W
) (
    input  logic             clk,
    input  logic             gen_reset,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    // Only the valid bits need clearing; a stale tag behind a cleared valid
    // bit can never produce a hit.
    always_ff @(posedge clk or negedge gen_reset) begin
        if (!gen_reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/cache_controller.sv
// Cache controller: sequences one CPU read or write at a time against a
// four-block data array (one block per word of a line) and main memory.
// Read hits are served from the array, read misses refill the whole line
// with a 4-beat burst and then re-look-up, writes go through to memory and
// update the array only on a hit (no write allocation).
// Ports:
//   clk, gen_reset (async, active-low)
//   CPU side   : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ready, cpu_rdata
//   Array side : cache_re, cache_we[3:0], cache_addr, cache_wdata,
//                cache_rdata1..4 (registered array outputs)
//   Memory side: mem_rreq, mem_wreq, mem_addr, mem_wdata,
//                mem_ack, mem_rvalid, mem_rdata
module cache_controller
    import cache_pkg::*;
#(
    parameter int bitsDirect  = CACHE_IDX_W,
    parameter int sizeBitLine = CACHE_DATA_W,
    parameter int TAG_W       = CACHE_TAG_W
) (
    input  logic                          clk,
    input  logic                          gen_reset,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [TAG_W+bitsDirect+1:0]   cpu_addr,
    input  logic [sizeBitLine-1:0]        cpu_wdata,
    output logic                          cpu_ready,
    output logic [sizeBitLine-1:0]        cpu_rdata,
    output logic                          cache_re,
    output logic [3:0]                    cache_we,
    output logic [bitsDirect-1:0]         cache_addr,
    output logic [sizeBitLine-1:0]        cache_wdata,
    input  logic [sizeBitLine-1:0]        cache_rdata1,
    input  logic [sizeBitLine-1:0]        cache_rdata2,
    input  logic [sizeBitLine-1:0]        cache_rdata3,
    input  logic [sizeBitLine-1:0]        cache_rdata4,
    output logic                          mem_rreq,
    output logic                          mem_wreq,
    output logic [TAG_W+bitsDirect+1:0]   mem_addr,
    output logic [sizeBitLine-1:0]        mem_wdata,
    input  logic                          mem_ack,
    input  logic                          mem_rvalid,
    input  logic [sizeBitLine-1:0]        mem_rdata
);

    localparam int ADDR_W = TAG_W + bitsDirect + 2;

    cache_state_t            state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    we_q, we_d;
    logic [sizeBitLine-1:0]  wdata_q, wdata_d;
    logic [sizeBitLine-1:0]  rdata_q, rdata_d;
    logic [1:0]              beat_q, beat_d;

    logic [1:0]              off;
    logic [bitsDirect-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit;
    logic                    tag_wr_en;
    logic [sizeBitLine-1:0]  blk_rdata [4];
    logic [sizeBitLine-1:0]  sel_rdata;

    assign off = addr_offset(addr_q);
    assign idx = addr_index(addr_q);
    assign tag = addr_tag(addr_q);

    assign blk_rdata[0] = cache_rdata1;
    assign blk_rdata[1] = cache_rdata2;
    assign blk_rdata[2] = cache_rdata3;
    assign blk_rdata[3] = cache_rdata4;
    assign sel_rdata    = blk_rdata[off];

    tag_store #(
        .IDX_W (bitsDirect),
        .TAG_W (TAG_W)
    ) u_tag_store (
        .clk       (clk),
        .gen_reset (gen_reset),
        .rd_idx    (idx),
        .rd_tag    (tag),
        .rd_hit    (hit),
        .wr_en     (tag_wr_en),
        .wr_idx    (idx),
        .wr_tag    (tag)
    );

    always_ff @(posedge clk or negedge gen_reset) begin
        if (!gen_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            beat_q  <= beat_d;
        end
    end

    // Read data is passed straight from the array during RESPOND and then
    // held from the register until the next read completes.
    assign cpu_rdata = (state_q == RESPOND && !we_q) ? sel_rdata : rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        beat_d      = beat_q;
        tag_wr_en   = 1'b0;
        cpu_ready   = 1'b0;
        cache_re    = 1'b0;
        cache_we    = 4'b0000;
        cache_addr  = '0;
        cache_wdata = '0;
        mem_rreq    = 1'b0;
        mem_wreq    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                cache_addr = idx;
                if (!we_q) begin
                    // Only reads touch the read port, so an array read and
                    // an array write never share a cycle.
                    cache_re = 1'b1;
                    state_d  = hit ? RESPOND : FILL_REQ;
                end else begin
                    if (hit) begin
                        cache_we    = 4'b0001 << off;
                        cache_wdata = wdata_q;
                    end
                    state_d = WRITE_MEM;
                end
            end

            FILL_REQ: begin
                mem_rreq = 1'b1;
                mem_addr = {tag, idx, 2'b00};
                if (mem_ack) begin
                    beat_d  = 2'd0;
                    state_d = FILL;
                end
            end

            FILL: begin
                cache_addr = idx;
                if (mem_rvalid) begin
                    cache_we    = 4'b0001 << beat_q;
                    cache_wdata = mem_rdata;
                    beat_d      = beat_q + 2'd1;
                    // The line becomes valid only once all four words are in.
                    if (beat_q == 2'd3) begin
                        tag_wr_en = 1'b1;
                        state_d   = LOOKUP;
                    end
                end
            end

            WRITE_MEM: begin
                mem_wreq  = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    state_d = RESPOND;
                end
            end

            RESPOND: begin
                cpu_ready = 1'b1;
                if (!we_q) begin
                    rdata_d = sel_rdata;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
